tune_sequencer: RTL and testbench

Plays a stored melody on the speaker pin. Fetches note entries from an external synchronous tune ROM and splits each 6-bit note number into octave and semitone with a divide_by12 instance. Generates a square wave at the note's pitch for a programmed number of tempo ticks, then advances to the next entry. Sits between the top-level start/stop controls and the speaker output.

---
 rtl/tune_pkg.sv | 39 +++
 rtl/divide_by12.sv | 36 +++
 rtl/tune_sequencer_pitch_gen.sv | 64 ++++++
 rtl/tune_sequencer.sv | 160 ++++++++++++++++
 tb/tb_tune_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tune_pkg.sv
// Shared definitions for tune_sequencer: ROM word layout, note divider
// table and the sequencer state encoding.
// Optional feature macro: TUNE_SEQUENCER_NOTE_GAP_EN adds the GAP state.
package tune_pkg;

   // ROM word layout: [10]=end, [9]=rest, [8:6]=dur, [5:0]=note
   localparam int unsigned ROM_W    = 11;
   localparam int unsigned END_BIT  = 10;
   localparam int unsigned REST_BIT = 9;
   localparam int unsigned DUR_LSB  = 6;
   localparam int unsigned DUR_W    = 3;
   localparam int unsigned NOTE_LSB = 0;
   localparam int unsigned NOTE_W   = 6;

   // Per-semitone clock divider, index 0 (lowest pitch) at the right
   localparam logic [11:0][9:0] NOTE_DIV = {
      10'd271, 10'd287, 10'd304, 10'd323, 10'd342, 10'd362,
      10'd384, 10'd406, 10'd431, 10'd456, 10'd483, 10'd512
   };

   function automatic logic [9:0] note_div(input logic [3:0] semitone);
      if (semitone < 4'd12) begin
         note_div = NOTE_DIV[semitone];
      end else begin
         note_div = NOTE_DIV[0];
      end
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY
`ifdef TUNE_SEQUENCER_NOTE_GAP_EN
      , ST_GAP
`endif
   } state_t;

endpackage

// File: rtl/divide_by12.sv
// Splits a 6-bit note number into octave (note/12) and semitone (note%12).
// note = 4*hi + lo, so note/12 = hi/3 and note%12 = 4*(hi%3) + lo.
module divide_by12 (
   input  logic [5:0] numerator,
   output logic [2:0] quotient,
   output logic [3:0] remainder
);

   logic [1:0] hi_rem;

   // divide the upper four bits by 3 with a lookup table
   always_comb begin
      quotient = '0;
      hi_rem   = '0;
      case (numerator[5:2])
         4'd0:  begin quotient = 3'd0; hi_rem = 2'd0; end
         4'd1:  begin quotient = 3'd0; hi_rem = 2'd1; end
         4'd2:  begin quotient = 3'd0; hi_rem = 2'd2; end
         4'd3:  begin quotient = 3'd1; hi_rem = 2'd0; end
         4'd4:  begin quotient = 3'd1; hi_rem = 2'd1; end
         4'd5:  begin quotient = 3'd1; hi_rem = 2'd2; end
         4'd6:  begin quotient = 3'd2; hi_rem = 2'd0; end
         4'd7:  begin quotient = 3'd2; hi_rem = 2'd1; end
         4'd8:  begin quotient = 3'd2; hi_rem = 2'd2; end
         4'd9:  begin quotient = 3'd3; hi_rem = 2'd0; end
         4'd10: begin quotient = 3'd3; hi_rem = 2'd1; end
         4'd11: begin quotient = 3'd3; hi_rem = 2'd2; end
         4'd12: begin quotient = 3'd4; hi_rem = 2'd0; end
         4'd13: begin quotient = 3'd4; hi_rem = 2'd1; end
         4'd14: begin quotient = 3'd4; hi_rem = 2'd2; end
         default: begin quotient = 3'd5; hi_rem = 2'd0; end
      endcase
      remainder = {hi_rem, numerator[1:0]};
   end

endmodule

// File: rtl/tune_sequencer_pitch_gen.sv
// Square-wave pitch generator. note_cnt divides by NOTE_DIV[semitone];
// each wrap steps oct_cnt down, and oct_cnt reaching 0 reloads (255>>octave)
// and toggles the speaker. The octave/semitone split is done by the parent.
module pitch_gen
   import tune_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] octave_i,
   input  logic [3:0] semitone_i,
   input  logic       enable_i,
   input  logic       clear_i,
   output logic       speaker_o
);

   logic [9:0] note_cnt_q, note_cnt_d;
   logic [7:0] oct_cnt_q, oct_cnt_d;
   logic       spk_q, spk_d;
   logic [9:0] div;
   logic [7:0] reload;

   // next-state for the two cascaded dividers and the toggle flop
   always_comb begin
      div        = note_div(semitone_i);
      reload     = 8'hFF >> octave_i;
      note_cnt_d = note_cnt_q;
      oct_cnt_d  = oct_cnt_q;
      spk_d      = spk_q;
      if (clear_i) begin
         // preload oct_cnt so the first half period is already full length
         note_cnt_d = '0;
         oct_cnt_d  = reload;
         spk_d      = 1'b0;
      end else if (enable_i) begin
         if (note_cnt_q == div - 10'd1) begin
            note_cnt_d = '0;
            if (oct_cnt_q == '0) begin
               oct_cnt_d = reload;
               spk_d     = ~spk_q;
            end else begin
               oct_cnt_d = oct_cnt_q - 8'd1;
            end
         end else begin
            note_cnt_d = note_cnt_q + 10'd1;
         end
      end
   end

   // counter and toggle registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         note_cnt_q <= '0;
         oct_cnt_q  <= '0;
         spk_q      <= 1'b0;
      end else begin
         note_cnt_q <= note_cnt_d;
         oct_cnt_q  <= oct_cnt_d;
         spk_q      <= spk_d;
      end
   end

   assign speaker_o = spk_q;

endmodule

// File: rtl/tune_sequencer.sv
// Melody player: fetches note entries from a synchronous tune ROM and plays
// each as a square wave for (dur+1) tempo ticks.
// Optional feature macro: TUNE_SEQUENCER_NOTE_GAP_EN inserts a silent
// one-tick GAP after every note.
module tune_sequencer
   import tune_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 2**22,
   parameter int unsigned ROM_AW      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [ROM_W-1:0]  rom_data,
   output logic              speaker,
   output logic              busy,
   output logic              done
);

   localparam int unsigned    TW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);

   state_t             state_q, state_d;
   logic [ROM_AW-1:0]  addr_q, addr_d;
   logic [NOTE_W-1:0]  note_q, note_d;
   logic               rest_q, rest_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic               done_q, done_d;
   logic               tick_last;
   logic               pitch_clr;
   logic               pitch_en;
   logic [NOTE_W-1:0]  note_sel;
   logic [2:0]         octave;
   logic [3:0]         semitone;
   logic               spk_raw;

   // sequencer next-state, ROM address and note latch; stop wins over all
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      note_d    = note_q;
      rest_d    = rest_q;
      dur_d     = dur_q;
      dur_cnt_d = dur_cnt_q;
      tick_d    = tick_q;
      done_d    = 1'b0;
      pitch_clr = 1'b0;
      tick_last = (tick_q == TICK_LAST);
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_FETCH;
                  addr_d  = '0;
               end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
               if (rom_data[END_BIT]) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  note_d    = rom_data[NOTE_LSB +: NOTE_W];
                  rest_d    = rom_data[REST_BIT];
                  dur_d     = rom_data[DUR_LSB +: DUR_W];
                  dur_cnt_d = '0;
                  tick_d    = '0;
                  pitch_clr = 1'b1;
                  state_d   = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (tick_last) begin
                  tick_d = '0;
                  if (dur_cnt_q == dur_q) begin
`ifdef TUNE_SEQUENCER_NOTE_GAP_EN
                     state_d = ST_GAP;
`else
                     addr_d  = addr_q + ROM_AW'(1);
                     state_d = ST_FETCH;
`endif
                  end else begin
                     dur_cnt_d = dur_cnt_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`ifdef TUNE_SEQUENCER_NOTE_GAP_EN
            ST_GAP: begin
               if (tick_last) begin
                  tick_d  = '0;
                  addr_d  = addr_q + ROM_AW'(1);
                  state_d = ST_FETCH;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // sequencer state and note registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         note_q    <= '0;
         rest_q    <= 1'b0;
         dur_q     <= '0;
         dur_cnt_q <= '0;
         tick_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         note_q    <= note_d;
         rest_q    <= rest_d;
         dur_q     <= dur_d;
         dur_cnt_q <= dur_cnt_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
      end
   end

   // In LOAD the pitch generator is cleared in the same edge that latches
   // the note, so its reload value must come straight from the ROM word.
   assign note_sel = (state_q == ST_LOAD) ? rom_data[NOTE_LSB +: NOTE_W] : note_q;
   assign pitch_en = (state_q == ST_PLAY);

   divide_by12 u_div12 (
      .numerator (note_sel),
      .quotient  (octave),
      .remainder (semitone)
   );

   pitch_gen u_pitch (
      .clk        (clk),
      .rst        (rst),
      .octave_i   (octave),
      .semitone_i (semitone),
      .enable_i   (pitch_en),
      .clear_i    (pitch_clr),
      .speaker_o  (spk_raw)
   );

   assign rom_addr = addr_q;
   assign speaker  = spk_raw & pitch_en & ~rest_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed scoreboard bench for tune_sequencer (TICK_CYCLES=8192) plus a
// small ROM_AW=2 instance for address wrap. Sample index k counts falling
// edges after the one at which start is driven (k=0).
module tb_tune_sequencer;

   localparam int TICK = 8192;
`ifdef TUNE_SEQUENCER_NOTE_GAP_EN
   localparam int GAP = TICK;
`else
   localparam int GAP = 0;
`endif

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic [7:0]  rom_addr;
   logic [10:0] rom_data;
   logic        speaker, busy, done;
   logic [10:0] mem [256];

   logic        start_w, stop_w;
   logic [1:0]  rom_addr_w;
   logic [10:0] rom_data_w;
   logic        speaker_w, busy_w, done_w;
   logic [10:0] mem_w [4];

   exp_t sb[$];
   int   edges_q[$];
   int   addrs_q[$];
   int   busy_fall, done_cnt, done_at;
   int   n_assert = 0;
   int   n_fail   = 0;

   localparam logic [10:0] W_END = 11'h400;

   always #5 clk = ~clk;

   tune_sequencer #(.TICK_CYCLES(TICK), .ROM_AW(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .rom_addr(rom_addr),
      .rom_data(rom_data), .speaker(speaker), .busy(busy), .done(done)
   );

   tune_sequencer #(.TICK_CYCLES(4), .ROM_AW(2)) u_wrap (
      .clk(clk), .rst(rst), .start(start_w), .stop(stop_w), .rom_addr(rom_addr_w),
      .rom_data(rom_data_w), .speaker(speaker_w), .busy(busy_w), .done(done_w)
   );

   // synchronous tune ROMs
   always @(posedge clk) begin
      rom_data   <= mem[rom_addr];
      rom_data_w <= mem_w[rom_addr_w];
   end

   function automatic logic [10:0] word(input bit rest, input int dur, input int note);
      logic [2:0] d;
      logic [5:0] n;
      d = 3'(dur);
      n = 6'(note);
      return {1'b0, rest, d, n};
   endfunction

   function automatic void push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      n_assert++;
      assert (obs === 32'(expv)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_next(input int obs, output int expv);
      exp_t e;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL sb_underflow: observed %0d expected none", obs);
         expv = 0;
      end else begin
         e = sb.pop_front();
         n_assert++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
         expv = e.val;
      end
   endtask

   // pushes the per-run trailer in the order compare_run pops it
   function automatic void push_tail(input int bfall, input int dcnt, input int dat);
      push("busy_fall", bfall);
      push("done_count", dcnt);
      push("done_at", dat);
   endfunction

   task automatic compare_run();
      int n, e;
      check_next(edges_q.size(), n);
      for (int i = 0; i < n; i++) check_next((i < edges_q.size()) ? edges_q[i] : -1, e);
      check_next(busy_fall, e);
      check_next(done_cnt, e);
      check_next(done_at, e);
      check_next(addrs_q.size(), n);
      for (int i = 0; i < n; i++) check_next((i < addrs_q.size()) ? addrs_q[i] : -1, e);
   endtask

   // start playback at the current falling edge and record what happens
   task automatic play(input int stop_at, input int quit_at, input int restart_at, input int budget);
      logic       prev_spk;
      logic [7:0] prev_addr;
      edges_q.delete();
      addrs_q.delete();
      busy_fall = -1;
      done_cnt  = 0;
      done_at   = -1;
      prev_spk  = speaker;
      prev_addr = rom_addr;
      start     = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         stop  = (k == stop_at);
         if (speaker !== prev_spk) begin
            edges_q.push_back(k);
            prev_spk = speaker;
         end
         if (k == 1 || rom_addr !== prev_addr) begin
            addrs_q.push_back(int'(rom_addr));
            prev_addr = rom_addr;
         end
         if (done) begin
            done_cnt++;
            done_at = k;
         end
         if (!busy) begin
            busy_fall = k;
            break;
         end
         if (k == quit_at) break;
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      int p1, e, low_cnt, done_w_cnt;
      int wseq[$];
      logic [1:0] prev_w;

      rst = 1'b1; start = 1'b0; stop = 1'b0; start_w = 1'b0; stop_w = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = W_END;
      for (int i = 0; i < 4; i++) mem_w[i] = word(1'b0, 0, 60);
      mem[0] = word(1'b0, 1, 60);
      mem[1] = W_END;

      repeat (2) @(negedge clk);
      chk("rst_speaker", speaker, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_addr", rom_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // start and stop together while idle: stays idle
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("idle_start_stop_busy", busy, 0);

      // stop mid-note at k=5000 while speaker is high
      push("stop_n_edges", 2); push("stop_rise", 4099); push("stop_fall", 5001);
      push_tail(5001, 0, -1);
      push("stop_n_addrs", 1); push("stop_addr0", 0);
      play(5000, -1, -1, 20000);
      compare_run();

      // full replay from address 0; start at k=100 is ignored while busy
      push("basic_n_edges", 4);
      push("basic_rise1", 4099); push("basic_fall1", 8195);
      push("basic_rise2", 12291); push("basic_fall2", 16387);
      push_tail(16389 + GAP, 1, 16389 + GAP);
      push("basic_n_addrs", 2); push("basic_addr0", 0); push("basic_addr1", 1);
      play(-1, -1, 100, 40000);
      compare_run();
      @(negedge clk);
      chk("basic_done_single", done, 0);

      // note 23: octave 1, semitone 11 -> half period 271*128
      mem[0] = word(1'b0, 4, 23);
      push("n23_n_edges", 2); push("n23_rise", 3 + 34688); push("n23_fall", 34701);
      push_tail(34701, 0, -1);
      push("n23_n_addrs", 1); push("n23_addr0", 0);
      play(34700, -1, -1, 40000);
      compare_run();

      // rest entry, then a normal note, then asynchronous reset mid-note
      mem[0] = word(1'b1, 0, 60);
      mem[1] = word(1'b0, 0, 60);
      mem[2] = W_END;
      p1 = 8197 + GAP;
      push("rest_n_edges", 1); push("rest_next_rise", p1 + 4096);
      push_tail(-1, 0, -1);
      push("rest_n_addrs", 2); push("rest_addr0", 0); push("rest_addr1", 1);
      play(-1, p1 + 4200, -1, 40000);
      compare_run();
      chk("pre_rst_speaker", speaker, 1);
      chk("pre_rst_addr", rom_addr, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_speaker", speaker, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_addr", rom_addr, 0);
      chk("async_rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ROM_AW=2 with no end marker: address wraps, busy stays high
      push("wrap_n_addrs", 6);
      push("wrap_a0", 0); push("wrap_a1", 1); push("wrap_a2", 2);
      push("wrap_a3", 3); push("wrap_a4", 0); push("wrap_a5", 1);
      push("wrap_busy_low", 0); push("wrap_done", 0);
      low_cnt = 0; done_w_cnt = 0; prev_w = rom_addr_w;
      start_w = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start_w = 1'b0;
         if (!busy_w) low_cnt++;
         if (done_w) done_w_cnt++;
         if (k == 1 || rom_addr_w !== prev_w) begin
            wseq.push_back(int'(rom_addr_w));
            prev_w = rom_addr_w;
         end
         if (wseq.size() == 6) break;
      end
      check_next(wseq.size(), e);
      for (int i = 0; i < 6; i++) check_next((i < wseq.size()) ? wseq[i] : -1, e);
      check_next(low_cnt, e);
      check_next(done_w_cnt, e);
      stop_w = 1'b1;
      @(negedge clk);
      stop_w = 1'b0;
      chk("wrap_stop_busy", busy_w, 0);
      chk("wrap_stop_speaker", speaker_w, 0);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
